// File: rtl/ledpwm_pkg.sv
// Shared constants for the iomem LED PWM controller.
package ledpwm_pkg;

  // Register word indices, compared against iomem_addr[4:2]
  localparam logic [2:0] LEDPWM_CTRL     = 3'd0;
  localparam logic [2:0] LEDPWM_PRESCALE = 3'd1;
  localparam logic [2:0] LEDPWM_DUTY_LO  = 3'd2;
  localparam logic [2:0] LEDPWM_DUTY_HI  = 3'd3;
  localparam logic [2:0] LEDPWM_STATUS   = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

endpackage

// File: rtl/ledpwm_timebase.sv
// Prescaler plus 8-bit PWM step counter. The counter wrap marks the period boundary.
module ledpwm_timebase #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,     // hold pc and cnt at 0
  input  logic                  i_pc_clr,    // restart tick spacing
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick,
  output logic [7:0]            o_cnt,
  output logic                  o_wrap
);

  logic [PRESCALE_W-1:0] r_pc;
  logic [7:0]            r_cnt;

  assign o_tick = ~i_clear && (r_pc == i_prescale);
  assign o_wrap = o_tick && (r_cnt == 8'hFF);
  assign o_cnt  = r_cnt;

  // Prescale counter runs 0..prescale; each tick advances the PWM step
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_pc  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_pc_clr || o_tick) r_pc <= '0;
      else                    r_pc <= r_pc + 1'b1;
      if (o_tick) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iomem_ledpwm.sv
// 8-channel LED PWM on the PicoSoC iomem bus: decode, registers, shadowed duty, compare.
module iomem_ledpwm
  import ledpwm_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0310_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  leds
);

  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic                  r_en, r_inv;
  logic [PRESCALE_W-1:0] r_pre;
  logic [7:0][7:0]       r_shd, r_act;
  logic [15:0]           r_period;
  logic [7:0]            r_leds;

  logic                  w_sel, w_acc, w_wr, w_ctrl_wr, w_en_rise, w_pre_wr;
  logic [2:0]            w_idx;
  logic [31:0]           w_rd, w_pre_tmp;
  logic                  w_tick, w_wrap;
  logic [7:0]            w_cnt;
  logic                  w_unused;

  // A matched request is accepted only when ready was low, forcing a gap cycle
  assign w_sel     = iomem_valid && (iomem_addr[31:5] == ADDR_BASE[31:5]);
  assign w_acc     = w_sel && !r_ready;
  assign w_wr      = w_acc && (|iomem_wstrb);
  assign w_idx     = iomem_addr[4:2];
  assign w_ctrl_wr = w_wr && (w_idx == LEDPWM_CTRL) && iomem_wstrb[0];
  assign w_en_rise = w_ctrl_wr && iomem_wdata[CTRL_EN] && !r_en;
  assign w_pre_wr  = w_wr && (w_idx == LEDPWM_PRESCALE);
  assign w_unused  = ^{iomem_addr[1:0], w_pre_tmp};

  ledpwm_timebase #(.PRESCALE_W(PRESCALE_W)) u_tb (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_clear    (!r_en),
    .i_pc_clr   (w_pre_wr),
    .i_prescale (r_pre),
    .o_tick     (w_tick),
    .o_cnt      (w_cnt),
    .o_wrap     (w_wrap)
  );

  // Read mux and byte-merged prescale write value
  always_comb begin
    w_rd      = '0;
    w_pre_tmp = 32'(r_pre);
    for (int b = 0; b < 4; b++)
      if (iomem_wstrb[b]) w_pre_tmp[b*8 +: 8] = iomem_wdata[b*8 +: 8];
    case (w_idx)
      LEDPWM_CTRL:     w_rd = {30'd0, r_inv, r_en};
      LEDPWM_PRESCALE: w_rd = 32'(r_pre);
      LEDPWM_DUTY_LO:  w_rd = r_shd[3:0];
      LEDPWM_DUTY_HI:  w_rd = r_shd[7:4];
      LEDPWM_STATUS:   w_rd = {16'd0, r_period};
      default:         w_rd = '0;
    endcase
  end

  // Bus handshake: one-cycle ready with registered read data, zero otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_acc ? w_rd : '0;
    end
  end

  // Register file writes, byte strobes honoured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en  <= 1'b0;
      r_inv <= 1'b0;
      r_pre <= '0;
      r_shd <= '0;
    end else if (w_wr) begin
      if (w_ctrl_wr) begin
        r_en  <= iomem_wdata[CTRL_EN];
        r_inv <= iomem_wdata[CTRL_INV];
      end
      if (w_pre_wr) r_pre <= w_pre_tmp[PRESCALE_W-1:0];
      for (int b = 0; b < 4; b++) begin
        if (iomem_wstrb[b] && w_idx == LEDPWM_DUTY_LO) r_shd[b]   <= iomem_wdata[b*8 +: 8];
        if (iomem_wstrb[b] && w_idx == LEDPWM_DUTY_HI) r_shd[b+4] <= iomem_wdata[b*8 +: 8];
      end
    end
  end

  // Active duty follows shadow while disabled, on enable, and at each period boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_act <= '0;
    else if (!r_en || w_en_rise || w_wrap) r_act <= r_shd;
  end

  // Period counter: cleared on enable, bumped at every boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_period <= '0;
    else if (w_en_rise) r_period <= '0;
    else if (w_wrap)    r_period <= r_period + 16'd1;
  end

  // Per-channel compare, registered so leds lag cnt by one stage
  for (genvar i = 0; i < 8; i++) begin : g_ch
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_leds[i] <= 1'b0;
      else       r_leds[i] <= (r_en && (w_cnt < r_act[i])) ^ r_inv;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign leds        = r_leds;

endmodule
